icache_fill_sched: RTL and testbench

ICACHE_FILL_SCHED -- requirements
Module: icache_fill_sched

---
 rtl/icache_fill_sched.sv | 185 ++++++++++++++++++
 tb/tb_icache_fill_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_sched.sv
// Instruction-cache fill scheduler: arbitrates demand/prefetch requests into the request
// queue and replays queued lines as memory bursts. Optional macro: ICACHE_FILL_DEDUP_EN.
`timescale 1ns/1ps

// state    | meaning
// ST_IDLE  | waiting for a queued line; pops the head when the queue is not empty
// ST_ISSUE | burst request held on the memory port until accepted
// ST_DATA  | writing returned beats into the cache line
module icache_fill_sched #(
  parameter int ADDRBITS     = 32,
  parameter int DATABITS     = 32,
  parameter int QUEUECNTBITS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                dem_req,
  input  logic [ADDRBITS-1:0] dem_addr,
  input  logic [1:0]          dem_wordlen,
  output logic                dem_ack,
  input  logic                pf_req,
  input  logic [ADDRBITS-1:0] pf_addr,
  output logic                pf_ack,
  output logic                queue_push,
  output logic [ADDRBITS-1:0] queue_in_addr,
  output logic [1:0]          queue_in_wordlen,
  output logic                queue_pop,
  input  logic [ADDRBITS-1:0] queue_out_addr,
  input  logic [1:0]          queue_out_wordlen,
  input  logic                queue_not_empty,
  output logic                mem_rd_req,
  output logic [ADDRBITS-1:0] mem_rd_addr,
  output logic [1:0]          mem_rd_len,
  input  logic                mem_rd_ack,
  input  logic                mem_rdata_valid,
  input  logic [DATABITS-1:0] mem_rdata,
  output logic                fill_we,
  output logic [ADDRBITS-1:0] fill_addr,
  output logic [DATABITS-1:0] fill_data,
  output logic                fill_done
);

  localparam int QUEUESIZE = 2**QUEUECNTBITS;
  localparam logic [QUEUECNTBITS-1:0] CNT_DEM_LIM = QUEUECNTBITS'(QUEUESIZE-1);
  localparam logic [QUEUECNTBITS-1:0] CNT_PF_LIM  = QUEUECNTBITS'(QUEUESIZE-2);
  localparam logic [ADDRBITS-1:0]     WORD_BYTES  = ADDRBITS'(DATABITS/8);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DATA} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [QUEUECNTBITS-1:0] r_cnt;
  logic [ADDRBITS-1:0]     r_addr;
  logic [ADDRBITS-1:0]     r_fill_addr;
  logic [1:0]              r_len;
  logic [1:0]              r_beat_left;
  logic                    r_fill_done;

  logic                    w_dem_grant;
  logic                    w_pf_grant;
  logic                    w_grant;
  logic                    w_dup;
  logic [ADDRBITS-1:0]     w_req_addr;
  logic [1:0]              w_req_len;

  // Grants are gated by reset_n so every output reads zero while reset is held.
  assign w_dem_grant = reset_n & dem_req & (r_cnt < CNT_DEM_LIM);
  assign w_pf_grant  = reset_n & ~w_dem_grant & pf_req & (r_cnt < CNT_PF_LIM);
  assign w_grant     = w_dem_grant | w_pf_grant;
  assign w_req_addr  = w_dem_grant ? dem_addr : pf_addr;
  assign w_req_len   = w_dem_grant ? dem_wordlen : 2'd3;

`ifdef ICACHE_FILL_DEDUP_EN
  logic [ADDRBITS-5:0] r_last_line;

  assign w_dup = ((r_state != ST_IDLE) && (w_req_addr[ADDRBITS-1:4] == r_addr[ADDRBITS-1:4])) ||
                 ((r_cnt != '0) && (w_req_addr[ADDRBITS-1:4] == r_last_line));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_line <= '0;
    end else if (queue_push) begin
      r_last_line <= queue_in_addr[ADDRBITS-1:4];
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign dem_ack          = w_dem_grant;
  assign pf_ack           = w_pf_grant;
  assign queue_push       = w_grant & ~w_dup;
  assign queue_in_addr    = queue_push ? w_req_addr : '0;
  assign queue_in_wordlen = queue_push ? w_req_len : 2'd0;
  assign fill_done        = r_fill_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (queue_push && !queue_pop) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (!queue_push && queue_pop) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    queue_pop   = 1'b0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    mem_rd_len  = 2'd0;
    fill_we     = 1'b0;
    fill_addr   = '0;
    fill_data   = '0;
    case (r_state)
      ST_IDLE: begin
        if (queue_not_empty && reset_n) begin
          queue_pop   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = r_addr;
        mem_rd_len  = r_len;
        if (mem_rd_ack) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mem_rdata_valid) begin
          fill_we   = 1'b1;
          fill_addr = r_fill_addr;
          fill_data = mem_rdata;
          if (r_beat_left == 2'd0) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Beats remaining counts down to the terminal beat; the fill address wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_len       <= 2'd0;
      r_fill_addr <= '0;
      r_beat_left <= 2'd0;
      r_fill_done <= 1'b0;
    end else begin
      r_fill_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (queue_pop) begin
            r_addr      <= queue_out_addr;
            r_len       <= queue_out_wordlen;
            r_fill_addr <= queue_out_addr;
            r_beat_left <= queue_out_wordlen;
          end
        end
        ST_DATA: begin
          if (mem_rdata_valid) begin
            r_fill_addr <= r_fill_addr + WORD_BYTES;
            r_beat_left <= r_beat_left - 2'd1;
            if (r_beat_left == 2'd0) begin
              r_fill_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_sched.sv
// Scoreboard bench for icache_fill_sched: stimulus queues expected pushes, bursts, fills and
// completion pulses; a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps

module tb_icache_fill_sched;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dem_req, pf_req, dem_ack, pf_ack;
  logic [AW-1:0] dem_addr, pf_addr;
  logic [1:0]    dem_wordlen;
  logic          queue_push, queue_pop, queue_not_empty;
  logic [AW-1:0] queue_in_addr, queue_out_addr;
  logic [1:0]    queue_in_wordlen, queue_out_wordlen;
  logic          mem_rd_req, mem_rd_ack, mem_rdata_valid;
  logic [AW-1:0] mem_rd_addr;
  logic [1:0]    mem_rd_len;
  logic [DW-1:0] mem_rdata;
  logic          fill_we, fill_done;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic          spur;

  always #5 clk = ~clk;

  icache_fill_sched #(.ADDRBITS(AW), .DATABITS(DW), .QUEUECNTBITS(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .dem_req(dem_req), .dem_addr(dem_addr), .dem_wordlen(dem_wordlen), .dem_ack(dem_ack),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_ack(pf_ack),
    .queue_push(queue_push), .queue_in_addr(queue_in_addr), .queue_in_wordlen(queue_in_wordlen),
    .queue_pop(queue_pop), .queue_out_addr(queue_out_addr), .queue_out_wordlen(queue_out_wordlen),
    .queue_not_empty(queue_not_empty),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len), .mem_rd_ack(mem_rd_ack),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data), .fill_done(fill_done)
  );

  // Request queue model: 8 entries, 7 usable, reset by the same reset_n.
  logic [AW+1:0] q_mem [8];
  logic [2:0]    q_wp, q_rp;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_wp <= '0;
      q_rp <= '0;
    end else begin
      if (queue_push) begin
        q_mem[q_wp] <= {queue_in_wordlen, queue_in_addr};
        q_wp <= q_wp + 3'd1;
      end
      if (queue_pop) q_rp <= q_rp + 3'd1;
    end
  end
  assign queue_not_empty   = (q_wp != q_rp);
  assign queue_out_addr    = q_mem[q_rp][AW-1:0];
  assign queue_out_wordlen = q_mem[q_rp][AW+1:AW];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // Memory model: after an accepted burst, returns len+1 beats on consecutive cycles.
  initial begin
    logic          hs;
    logic [31:0]   m_addr;
    int            m_left;
    m_left = 0;
    m_addr = '0;
    mem_rdata_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      hs = mem_rd_req && mem_rd_ack;
      if (hs) m_addr = mem_rd_addr;
      if (hs) m_left = int'(mem_rd_len) + 1;
      @(posedge clk);
      #1;
      if (!reset_n) m_left = 0;
      if (m_left > 0) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = pat(m_addr);
        m_addr = m_addr + 32'd4;
        m_left--;
      end else begin
        mem_rdata_valid = spur;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  typedef struct packed {logic [31:0] a; logic [1:0] l;} req_t;
  typedef struct packed {logic [31:0] a; logic [31:0] d;} fill_t;
  req_t  exp_push[$];
  req_t  exp_burst[$];
  fill_t exp_fill[$];
  bit    exp_done[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    fill_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flagm(input string nm, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s, expected none", nm, what);
  endtask

  task automatic exp_hdr(input logic [31:0] a, input logic [1:0] l);
    exp_push.push_back('{a: a, l: l});
    exp_burst.push_back('{a: a, l: l});
    exp_done.push_back(1'b1);
  endtask

  task automatic exp_fill1(input logic [31:0] a);
    exp_fill.push_back('{a: a, d: pat(a)});
  endtask

  task automatic expect_req(input logic [31:0] a, input logic [1:0] l);
    exp_hdr(a, l);
    for (int i = 0; i <= int'(l); i++) exp_fill1(a + 32'(4 * i));
  endtask

  // Monitor: compares every DUT event against the head of its scoreboard queue.
  initial begin
    req_t  r;
    fill_t f;
    bit    d;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (queue_push) begin
          if (exp_push.size() == 0) flagm("push_unexpected", "a queue push");
          else begin
            r = exp_push.pop_front();
            chk("push_addr", 64'(queue_in_addr), 64'(r.a));
            chk("push_len", 64'(queue_in_wordlen), 64'(r.l));
          end
        end
        if (mem_rd_req && mem_rd_ack) begin
          if (exp_burst.size() == 0) flagm("burst_unexpected", "a burst request");
          else begin
            r = exp_burst.pop_front();
            chk("burst_addr", 64'(mem_rd_addr), 64'(r.a));
            chk("burst_len", 64'(mem_rd_len), 64'(r.l));
          end
        end
        if (fill_we) begin
          fill_seen++;
          if (exp_fill.size() == 0) flagm("fill_unexpected", "a fill write");
          else begin
            f = exp_fill.pop_front();
            chk("fill_addr", 64'(fill_addr), 64'(f.a));
            chk("fill_data", 64'(fill_data), 64'(f.d));
          end
        end
        if (fill_done) begin
          if (exp_done.size() == 0) flagm("done_unexpected", "a fill_done pulse");
          else d = exp_done.pop_front();
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dem(input logic [31:0] a, input logic [1:0] l, output int waited);
    bit got;
    dem_req = 1'b1;
    dem_addr = a;
    dem_wordlen = l;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (dem_ack) got = 1'b1;
      else waited++;
      cyc();
    end
    dem_req = 1'b0;
    if (!got) flagm("dem_ack_timeout", "no dem_ack within 200 cycles");
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_fill.size() + exp_done.size() + exp_burst.size() + exp_push.size()) != 0 && n < 400) begin
      cyc();
      n++;
    end
    if (n >= 400) flagm(nm, "outstanding expectations after 400 cycles");
    repeat (2) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, acks, stalls, n;
    reset_n = 1'b0;
    dem_req = 1'b1; dem_addr = 32'h1000; dem_wordlen = 2'd3;
    pf_req = 1'b0; pf_addr = '0;
    mem_rd_ack = 1'b0; spur = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("reset_ctl", 64'({dem_ack, pf_ack, queue_push, queue_pop, mem_rd_req, fill_we, fill_done}), 64'd0);
    chk("reset_addr", 64'(mem_rd_addr | fill_addr | queue_in_addr), 64'd0);
    dem_req = 1'b0;
    #2 reset_n = 1'b1;
    cyc();

    // Single demand, immediate memory ack
    mem_rd_ack = 1'b1;
    exp_hdr(32'h1000, 2'd3);
    exp_fill1(32'h1000); exp_fill1(32'h1004); exp_fill1(32'h1008); exp_fill1(32'h100C);
    dem(32'h1000, 2'd3, w);
    chk("t1_first_grant_latency", 64'(w), 64'd0);
    drain("t1_drain");
    chk("t1_queue_empty", 64'(queue_not_empty), 64'd0);

    // Demand and prefetch in the same cycle
    expect_req(32'h2000, 2'd1);
    expect_req(32'h3000, 2'd3);
    dem_req = 1'b1; dem_addr = 32'h2000; dem_wordlen = 2'd1;
    pf_req = 1'b1; pf_addr = 32'h3000;
    @(negedge clk);
    chk("t2_dem_ack_first", 64'(dem_ack), 64'd1);
    chk("t2_pf_ack_blocked", 64'(pf_ack), 64'd0);
    cyc();
    dem_req = 1'b0;
    @(negedge clk);
    chk("t2_pf_ack_second", 64'(pf_ack), 64'd1);
    cyc();
    pf_req = 1'b0;
    drain("t2_drain");

    // Queue limits with memory stalled
    mem_rd_ack = 1'b0;
    for (int k = 0; k < 7; k++) expect_req(32'h5000 + 32'(16 * k), 2'd3);
    expect_req(32'h6000, 2'd0);
    expect_req(32'h6010, 2'd0);
    acks = 0;
    pf_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      pf_addr = 32'h5000 + 32'(16 * k);
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        if (pf_ack) begin acks++; n = 100; end
        else n++;
        cyc();
      end
    end
    chk("t3_pf_grants", 64'(acks), 64'd7);
    pf_addr = 32'h5070;
    stalls = 0;
    repeat (5) begin @(negedge clk); if (pf_ack) stalls++; cyc(); end
    chk("t3_pf_stall_at_6", 64'(stalls), 64'd0);
    pf_req = 1'b0;
    dem(32'h6000, 2'd0, w);
    chk("t3_dem_grant_at_6", 64'(w), 64'd0);
    dem_req = 1'b1; dem_addr = 32'h6010; dem_wordlen = 2'd0;
    stalls = 0;
    repeat (5) begin @(negedge clk); if (dem_ack) stalls++; cyc(); end
    chk("t3_dem_stall_at_7", 64'(stalls), 64'd0);
    mem_rd_ack = 1'b1;
    dem(32'h6010, 2'd0, w);
    chk("t3_dem_grant_after_pop", 64'(w), 64'd6);
    drain("t3_drain");
    chk("t3_queue_empty", 64'(queue_not_empty), 64'd0);

    // Address wrap across the top of the address space
    exp_hdr(32'hFFFF_FFF8, 2'd3);
    exp_fill1(32'hFFFF_FFF8); exp_fill1(32'hFFFF_FFFC); exp_fill1(32'h0000_0000); exp_fill1(32'h0000_0004);
    dem(32'hFFFF_FFF8, 2'd3, w);
    drain("t4_drain");

    // Returned data while idle is ignored
    spur = 1'b1;
    n = 0;
    repeat (4) begin @(negedge clk); if (fill_we) n++; end
    spur = 1'b0;
    chk("t5_idle_valid_ignored", 64'(n), 64'd0);
    repeat (2) cyc();

    // Reset in the middle of a burst
    exp_push.push_back('{a: 32'h7000, l: 2'd3});
    exp_burst.push_back('{a: 32'h7000, l: 2'd3});
    exp_fill1(32'h7000); exp_fill1(32'h7004);
    n = fill_seen;
    dem(32'h7000, 2'd3, w);
    stalls = 0;
    while (fill_seen < n + 2 && stalls < 50) begin cyc(); stalls++; end
    if (stalls >= 50) flagm("t6_two_beats_timeout", "fewer than two beats within 50 cycles");
    #1 reset_n = 1'b0;
    #1;
    chk("t6_reset_ctl_now", 64'({dem_ack, pf_ack, queue_push, queue_pop, mem_rd_req, fill_we, fill_done}), 64'd0);
    chk("t6_reset_addr_now", 64'(mem_rd_addr | fill_addr | fill_data | queue_in_addr), 64'd0);
    cyc(); cyc();
    #3 reset_n = 1'b1;
    cyc();
    expect_req(32'h4000, 2'd3);
    dem(32'h4000, 2'd3, w);
    chk("t6_post_reset_grant_latency", 64'(w), 64'd0);
    drain("t6_drain");

    // Same line requested back to back
`ifdef ICACHE_FILL_DEDUP_EN
    expect_req(32'h1000, 2'd3);
`else
    expect_req(32'h1000, 2'd3);
    expect_req(32'h1000, 2'd3);
`endif
    dem(32'h1000, 2'd3, w);
    chk("t7_first_ack", 64'(w), 64'd0);
    dem(32'h1000, 2'd3, w);
    chk("t7_second_ack", 64'(w), 64'd0);
    drain("t7_drain");

    chk("end_queue_empty", 64'(queue_not_empty), 64'd0);
    chk("end_sb_pending", 64'(exp_push.size() + exp_burst.size() + exp_fill.size() + exp_done.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
